perf_counter_unit: RTL

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

---
 rtl/perf_counter_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/perf_counter_unit.sv
// Run/halt performance counter block: a saturating cycle counter plus NUM_EVT
// event counters, snapshot shadows and a one-cycle-latency shadow read port.
module perf_counter_unit #(
   parameter  int NUM_EVT = 2,
   parameter  int CNT_W   = 32,
   localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 clear_i,
   input  logic [NUM_EVT-1:0]   evt_i,
   input  logic [CNT_W-1:0]     limit_i,
   input  logic                 snap_i,
   input  logic                 rd_req_i,
   input  logic [SEL_W-1:0]     rd_sel_i,
   output logic                 rd_valid_o,
   output logic [CNT_W-1:0]     rd_data_o,
   output logic [1:0]           state_o,
   output logic                 halt_o,
   output logic [NUM_EVT:0]     ovf_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_EVT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_t               state_q, state_nxt;
   logic [CNT_W-1:0]     lim_q;
   logic [CNT_W-1:0]     cnt_q [NUM_EVT+1];
   logic [CNT_W-1:0]     shd_q [NUM_EVT+1];
   logic [NUM_EVT:0]     ovf_q;
   logic [NUM_EVT:0]     inc_req;
   logic [CNT_W-1:0]     cyc_inc;
   logic                 lim_hit;
   logic                 rd_vld_p1;
   logic [CNT_W-1:0]     rd_data_p1;

   // Slot 0 is the cycle counter and always requests an increment while running.
   assign inc_req = {evt_i, 1'b1};
   assign cyc_inc = sat_inc(cnt_q[0]);
   assign lim_hit = (lim_q != '0) && (cyc_inc == lim_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: if (start_i)           state_nxt = ST_RUN;
         ST_RUN:  if (stop_i || lim_hit) state_nxt = ST_HALT;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
      if (clear_i) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lim_q <= '0;
         ovf_q <= '0;
         for (int k = 0; k <= NUM_EVT; k++) begin
            cnt_q[k] <= '0;
            shd_q[k] <= '0;
         end
      end else if (clear_i) begin
         ovf_q <= '0;
         for (int k = 0; k <= NUM_EVT; k++) begin
            cnt_q[k] <= '0;
            shd_q[k] <= '0;
         end
      end else begin
         if (state_q == ST_IDLE && start_i) lim_q <= limit_i;
         for (int k = 0; k <= NUM_EVT; k++) begin
            if (snap_i) shd_q[k] <= cnt_q[k];
            if (state_q == ST_RUN && inc_req[k]) begin
               cnt_q[k] <= sat_inc(cnt_q[k]);
               if (cnt_q[k] == CNT_MAX) ovf_q[k] <= 1'b1;
            end
         end
      end
   end

   // Read stage p1: shadow contents as they stood before this edge's snapshot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_vld_p1  <= 1'b0;
         rd_data_p1 <= '0;
      end else begin
         rd_vld_p1  <= rd_req_i;
         rd_data_p1 <= (rd_req_i && rd_sel_i <= SEL_MAX) ? shd_q[rd_sel_i] : '0;
      end
   end

   assign rd_valid_o = rd_vld_p1;
   assign rd_data_o  = rd_data_p1;
   assign state_o    = state_q;
   assign halt_o     = (state_q == ST_HALT);
   assign ovf_o      = ovf_q;

endmodule
